wb_sram_slave: RTL and testbench

- Wishbone slave responder on the slave-0 port of the Wishbone interconnect.
- Accepts the interconnect's registered single-beat cycles and converts them into accesses on a single-port synchronous SRAM macro (OpenRAM-style: active-low csb/web, byte wmask).
- Returns read data and exactly one single-cycle ack per transaction.
- Sits between the interconnect's s0_* outputs and the SRAM macro.

---
 rtl/wb_sram_slave.sv | 126 ++++++++++++
 tb/tb_wb_sram_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone slave-0 responder driving a single-port synchronous SRAM macro.
// One single-cycle ack per transaction; a recovery cycle masks stale strobes.
module wb_sram_slave #(
    parameter int ADDR_W   = 9,
    parameter int SRAM_AW  = 7,
    parameter int READ_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [ADDR_W-1:0]  wb_adr_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               sram_csb_o,
    output logic               sram_web_o,
    output logic [3:0]         sram_wmask_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_din_o,
    input  logic [31:0]        sram_dout_i
);

    localparam logic [1:0] LAT = READ_LAT[1:0];

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        READ_WAIT,
        ACK,
        RECOVER
    } state_t;

    state_t             state, state_n;
    logic [1:0]         cnt, cnt_n;
    logic               ack_n;
    logic [31:0]        dat_n;
    logic               csb_n;
    logic               web_n;
    logic [3:0]         wmask_n;
    logic [SRAM_AW-1:0] addr_n;
    logic [31:0]        din_n;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= 32'd0;
            sram_csb_o   <= 1'b1;
            sram_web_o   <= 1'b1;
            sram_wmask_o <= 4'b0000;
            sram_addr_o  <= '0;
            sram_din_o   <= 32'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            wb_ack_o     <= ack_n;
            wb_dat_o     <= dat_n;
            sram_csb_o   <= csb_n;
            sram_web_o   <= web_n;
            sram_wmask_o <= wmask_n;
            sram_addr_o  <= addr_n;
            sram_din_o   <= din_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        dat_n   = wb_dat_o;
        csb_n   = 1'b1;
        web_n   = 1'b1;
        wmask_n = 4'b0000;
        addr_n  = sram_addr_o;
        din_n   = sram_din_o;
        unique case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_n = ACCESS;
                    addr_n  = wb_adr_i[ADDR_W-1:2];
                    din_n   = wb_dat_i;
                    web_n   = ~wb_we_i;
                    wmask_n = wb_we_i ? wb_sel_i : 4'b0000;
                    // an all-lanes-off write never touches the macro
                    csb_n   = wb_we_i && (wb_sel_i == 4'b0000);
                end
            end
            ACCESS: begin
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (!sram_web_o) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                end else begin
                    state_n = READ_WAIT;
                    cnt_n   = 2'd1;
                end
            end
            READ_WAIT: begin
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (cnt == LAT) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                    dat_n   = sram_dout_i;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            ACK: begin
                state_n = RECOVER;
            end
            RECOVER: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: READ_LAT=1 and READ_LAT=3 instances,
// each with its own SRAM model and its own cyc/stb pair.
module tb_wb_sram_slave;

    localparam logic [31:0] BAD = 32'hBADBAD00;

    logic        clk;
    logic        rst;
    logic [31:0] wdat;
    logic [8:0]  adr;
    logic [3:0]  sel;
    logic        we;
    logic        cyc1, stb1, cyc3, stb3;

    logic [31:0] dat1, dat3;
    logic        ack1, ack3;
    logic        csb1, csb3;
    logic        web1, web3;
    logic [3:0]  wm1, wm3;
    logic [6:0]  addr1, addr3;
    logic [31:0] din1, din3;
    logic [31:0] dout1, dout3;

    logic [31:0] mem1 [128];
    logic [31:0] mem3 [128];
    logic [31:0] rd1, p0, p1, p2;

    int n_chk  = 0;
    int n_pass = 0;
    int acc1 = 0, acc3 = 0, nack1 = 0, nack3 = 0;

    wb_sram_slave #(.ADDR_W(9), .SRAM_AW(7), .READ_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst),
        .wb_dat_i(wdat), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc1), .wb_stb_i(stb1),
        .wb_dat_o(dat1), .wb_ack_o(ack1),
        .sram_csb_o(csb1), .sram_web_o(web1), .sram_wmask_o(wm1),
        .sram_addr_o(addr1), .sram_din_o(din1), .sram_dout_i(dout1)
    );

    wb_sram_slave #(.ADDR_W(9), .SRAM_AW(7), .READ_LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst),
        .wb_dat_i(wdat), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc3), .wb_stb_i(stb3),
        .wb_dat_o(dat3), .wb_ack_o(ack3),
        .sram_csb_o(csb3), .sram_web_o(web3), .sram_wmask_o(wm3),
        .sram_addr_o(addr3), .sram_din_o(din3), .sram_dout_i(dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // read data is valid only in the one cycle before the capture edge
    always @(posedge clk) begin
        rd1 <= BAD;
        if (!csb1) begin
            if (!web1) begin
                for (int b = 0; b < 4; b++)
                    if (wm1[b]) mem1[addr1][8*b +: 8] <= din1[8*b +: 8];
            end else begin
                rd1 <= mem1[addr1];
            end
        end
    end
    assign dout1 = rd1;

    always @(posedge clk) begin
        p0 <= BAD;
        p1 <= p0;
        p2 <= p1;
        if (!csb3) begin
            if (!web3) begin
                for (int b = 0; b < 4; b++)
                    if (wm3[b]) mem3[addr3][8*b +: 8] <= din3[8*b +: 8];
            end else begin
                p0 <= mem3[addr3];
            end
        end
    end
    assign dout3 = p2;

    always @(posedge clk) begin
        if (!csb1) acc1++;
        if (!csb3) acc3++;
        if (ack1) nack1++;
        if (ack3) nack3++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit d3, input bit w, input logic [8:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else    begin cyc1 = 1'b1; stb1 = 1'b1; end
        tick();
        stb1 = 1'b0;
        stb3 = 1'b0;
    endtask

    task automatic wait_ack(input bit d3, input int lat, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            seen = d3 ? ack3 : ack1;
        end
        chk(tag, n, lat);
        cyc1 = 1'b0;
        cyc3 = 1'b0;
        tick();
        chk({tag, "_pulse"}, d3 ? ack3 : ack1, 0);
        tick();
    endtask

    initial begin
        int a0, k0, na, nk, nc, first;
        bit prev;
        rst = 1'b1; wdat = 0; adr = 0; sel = 0; we = 0;
        cyc1 = 0; stb1 = 0; cyc3 = 0; stb3 = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", ack1, 0);
        chk("rst_dat", dat1, 0);
        chk("rst_csb", csb1, 1);
        chk("rst_web", web1, 1);
        chk("rst_wmask", wm1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_din", din1, 0);
        chk("rst_csb3", csb3, 1);

        // full-word write
        a0 = acc1; k0 = nack1;
        do_req(0, 1, 9'h010, 32'hDEADBEEF, 4'hF);
        chk("wr_csb", csb1, 0);
        chk("wr_web", web1, 0);
        chk("wr_wmask", wm1, 4'hF);
        chk("wr_addr", addr1, 4);
        chk("wr_din", din1, 32'hDEADBEEF);
        chk("wr_ack_early", ack1, 0);
        tick();
        chk("wr_ack", ack1, 1);
        chk("wr_csb_rel", csb1, 1);
        chk("wr_wmask_rel", wm1, 0);
        chk("wr_addr_hold", addr1, 4);
        cyc1 = 0;
        tick();
        chk("wr_pulse", ack1, 0);
        tick();
        chk("wr_accesses", acc1 - a0, 1);
        chk("wr_acks", nack1 - k0, 1);

        // read, latency 1, unaligned byte address
        do_req(0, 0, 9'h013, 32'h0, 4'hF);
        chk("rd_csb", csb1, 0);
        chk("rd_web", web1, 1);
        chk("rd_addr", addr1, 4);
        chk("rd_wmask", wm1, 0);
        wait_ack(0, 2, "rd1_lat");
        chk("rd1_data", dat1, 32'hDEADBEEF);

        // single byte lane, merged read-back
        do_req(0, 1, 9'h010, 32'h0000AB00, 4'b0010);
        chk("lane_wmask", wm1, 4'b0010);
        wait_ack(0, 1, "lane_lat");
        do_req(0, 0, 9'h010, 32'h0, 4'hF);
        wait_ack(0, 2, "lane_rd_lat");
        chk("lane_merge", dat1, 32'hDEADABEF);

        // write with no lanes: no macro access, ack timing unchanged
        a0 = acc1;
        do_req(0, 1, 9'h010, 32'h12345678, 4'b0000);
        chk("sel0_csb", csb1, 1);
        wait_ack(0, 1, "sel0_lat");
        chk("sel0_accesses", acc1 - a0, 0);
        chk("sel0_dat_keep", dat1, 32'hDEADABEF);
        do_req(0, 0, 9'h010, 32'h0, 4'hF);
        wait_ack(0, 2, "sel0_rd_lat");
        chk("sel0_rd", dat1, 32'hDEADABEF);

        // latency-3 instance
        do_req(1, 1, 9'h010, 32'hDEADBEEF, 4'hF);
        wait_ack(1, 1, "l3_wr_lat");
        do_req(1, 0, 9'h013, 32'h0, 4'hF);
        chk("l3_rd_addr", addr3, 4);
        wait_ack(1, 4, "l3_rd_lat");
        chk("l3_rd_data", dat3, 32'hDEADBEEF);

        // strobe held high for 12 edges
        we = 1; adr = 9'h020; wdat = 32'hCAFEF00D; sel = 4'hF;
        cyc1 = 1; stb1 = 1;
        na = 0; nk = 0; nc = 0; first = 0; prev = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (!csb1) na++;
            if (ack1) begin
                nk++;
                if (first == 0) first = i;
                if (prev) nc++;
            end
            prev = ack1;
        end
        cyc1 = 0; stb1 = 0;
        tick();
        chk("stale_acks", nk, 3);
        chk("stale_accesses", na, 3);
        chk("stale_consec", nc, 0);
        chk("stale_first", first, 2);

        // abort during READ_WAIT, then a normal read
        do_req(1, 1, 9'h014, 32'h13579BDF, 4'hF);
        wait_ack(1, 1, "ab_wr_lat");
        k0 = nack3;
        do_req(1, 0, 9'h014, 32'h0, 4'hF);
        tick();
        cyc3 = 0;
        tick();
        chk("ab_ack", ack3, 0);
        chk("ab_dat_keep", dat3, 32'hDEADBEEF);
        do_req(1, 0, 9'h014, 32'h0, 4'hF);
        chk("ab_next_csb", csb3, 0);
        wait_ack(1, 4, "ab_next_lat");
        chk("ab_next_data", dat3, 32'h13579BDF);
        chk("ab_acks", nack3 - k0, 1);

        // reset during READ_WAIT
        do_req(1, 0, 9'h010, 32'h0, 4'hF);
        tick();
        tick();
        rst = 1; cyc3 = 0;
        tick();
        rst = 0;
        k0 = nack3;
        chk("mrst_ack", ack3, 0);
        chk("mrst_csb", csb3, 1);
        chk("mrst_web", web3, 1);
        chk("mrst_wmask", wm3, 0);
        chk("mrst_addr", addr3, 0);
        chk("mrst_din", din3, 0);
        chk("mrst_dat", dat3, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_no_ack", nack3 - k0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
